// File: rtl/trade_trigger_if.sv
// Comparator-result and order-request bundle for trade_trigger.
// The slave side (the trigger) consumes results and drives orders.
interface trade_trigger_if #(
    parameter int SYM_WIDTH   = 16,
    parameter int PRICE_WIDTH = 32
);
    logic                   cmp_valid;
    logic                   cond_true;
    logic [SYM_WIDTH-1:0]   cmp_sym_id;
    logic [PRICE_WIDTH-1:0] cmp_price;
    logic                   ord_valid;
    logic                   ord_ready;
    logic [SYM_WIDTH-1:0]   ord_sym_id;
    logic [PRICE_WIDTH-1:0] ord_price;

    modport master (
        output cmp_valid,
        output cond_true,
        output cmp_sym_id,
        output cmp_price,
        output ord_ready,
        input  ord_valid,
        input  ord_sym_id,
        input  ord_price
    );

    modport slave (
        input  cmp_valid,
        input  cond_true,
        input  cmp_sym_id,
        input  cmp_price,
        input  ord_ready,
        output ord_valid,
        output ord_sym_id,
        output ord_price
    );
endinterface

// File: rtl/trade_trigger.sv
// Issues one order after N consecutive same-symbol true comparator hits,
// then holds off new triggers for a fixed cooldown.
module trade_trigger #(
    parameter int SYM_WIDTH       = 16,
    parameter int PRICE_WIDTH     = 32,
    parameter int CNT_WIDTH       = 4,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_enable,
    input  logic [CNT_WIDTH-1:0] cfg_hit_thresh,
    trade_trigger_if.slave       bus,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);
    localparam int CD_W =
        (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_CYCLES);
    localparam logic [CD_W-1:0] CD_ONE = CD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOLDOWN
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [SYM_WIDTH-1:0]   trk_sym_q, trk_sym_d;
    logic [SYM_WIDTH-1:0]   ord_sym_q, ord_sym_d;
    logic [PRICE_WIDTH-1:0] ord_price_q, ord_price_d;
    logic [CD_W-1:0]        cd_cnt_q, cd_cnt_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                 hit;
    logic                 same_sym;
    logic [CNT_WIDTH-1:0] thresh_eff;
    logic [CNT_WIDTH-1:0] hit_next;

    assign hit        = bus.cmp_valid && bus.cond_true;
    assign same_sym   = (bus.cmp_sym_id == trk_sym_q);
    assign thresh_eff = (cfg_hit_thresh == '0) ? CNT_ONE : cfg_hit_thresh;

    // A streak continues only on the tracked symbol; otherwise restart at 1.
    always_comb begin
        hit_next = CNT_ONE;
        if (hit_cnt_q != '0 && same_sym) begin
            hit_next = (hit_cnt_q == CNT_MAX) ? CNT_MAX
                                              : hit_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        hit_cnt_d   = hit_cnt_q;
        trk_sym_d   = trk_sym_q;
        ord_sym_d   = ord_sym_q;
        ord_price_d = ord_price_q;
        cd_cnt_d    = cd_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (!cfg_enable) begin
                    hit_cnt_d = '0;
                end else if (bus.cmp_valid) begin
                    if (!bus.cond_true) begin
                        hit_cnt_d = '0;
                    end else begin
                        hit_cnt_d = hit_next;
                        trk_sym_d = bus.cmp_sym_id;
                        if (hit_next >= thresh_eff) begin
                            ord_sym_d   = bus.cmp_sym_id;
                            ord_price_d = bus.cmp_price;
                            hit_cnt_d   = '0;
                            state_d     = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (bus.ord_ready) begin
                    if (COOLDOWN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = COOLDOWN;
                        cd_cnt_d = CD_INIT;
                    end
                end
            end
            COOLDOWN: begin
                cd_cnt_d = cd_cnt_q - CD_ONE;
                if (cd_cnt_q <= CD_ONE) begin
                    cd_cnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hits that arrive while an order is outstanding are lost; count them.
        if (state_q != IDLE && hit && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hit_cnt_q   <= '0;
            trk_sym_q   <= '0;
            ord_sym_q   <= '0;
            ord_price_q <= '0;
            cd_cnt_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hit_cnt_q   <= hit_cnt_d;
            trk_sym_q   <= trk_sym_d;
            ord_sym_q   <= ord_sym_d;
            ord_price_q <= ord_price_d;
            cd_cnt_q    <= cd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.ord_valid  = (state_q == ISSUE);
    assign bus.ord_sym_id = ord_sym_q;
    assign bus.ord_price  = ord_price_q;
    assign busy           = (state_q != IDLE);
    assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_trade_trigger.sv
// Bench for trade_trigger: two instances (cooldown 8 and 0) share stimulus
// and are compared each cycle against an order/cooldown reference model.
module tb_trade_trigger;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic [3:0]  cfg_hit_thresh;
    logic        busy0, busy1;
    logic [15:0] drop0, drop1;

    trade_trigger_if #(.SYM_WIDTH(16), .PRICE_WIDTH(32)) b0 ();
    trade_trigger_if #(.SYM_WIDTH(16), .PRICE_WIDTH(32)) b1 ();

    trade_trigger #(
        .SYM_WIDTH(16), .PRICE_WIDTH(32),
        .CNT_WIDTH(4), .COOLDOWN_CYCLES(8)
    ) u0 (
        .clk(clk), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_hit_thresh(cfg_hit_thresh),
        .bus(b0), .busy(busy0), .drop_cnt(drop0)
    );

    trade_trigger #(
        .SYM_WIDTH(16), .PRICE_WIDTH(32),
        .CNT_WIDTH(4), .COOLDOWN_CYCLES(0)
    ) u1 (
        .clk(clk), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_hit_thresh(cfg_hit_thresh),
        .bus(b1), .busy(busy1), .drop_cnt(drop1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: is an order outstanding, how many cooldown
    // cycles remain, the current streak and what it is on.
    int          cd_len [2] = '{8, 0};
    bit          m_pend [2];
    int          m_cool [2];
    int          m_streak [2];
    logic [15:0] m_sym [2];
    logic [15:0] m_osym [2];
    logic [31:0] m_oprice [2];
    int          m_drop [2];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]   = 1'b0;
            m_cool[i]   = 0;
            m_streak[i] = 0;
            m_sym[i]    = '0;
            m_osym[i]   = '0;
            m_oprice[i] = '0;
            m_drop[i]   = 0;
        end
    endtask

    task automatic model_edge(input logic v, input logic t,
                              input logic [15:0] sym,
                              input logic [31:0] price,
                              input logic rdy);
        int th;
        th = (cfg_hit_thresh == 0) ? 1 : int'(cfg_hit_thresh);
        for (int i = 0; i < 2; i++) begin
            if (m_pend[i] || m_cool[i] > 0) begin
                if (v && t && m_drop[i] < 65535) m_drop[i]++;
                if (m_pend[i]) begin
                    if (rdy) begin
                        m_pend[i] = 1'b0;
                        m_cool[i] = cd_len[i];
                    end
                end else begin
                    m_cool[i]--;
                end
            end else if (!cfg_enable) begin
                m_streak[i] = 0;
            end else if (v) begin
                if (!t) begin
                    m_streak[i] = 0;
                end else begin
                    if (m_streak[i] > 0 && sym == m_sym[i])
                        m_streak[i] = (m_streak[i] >= 15) ? 15
                                                          : m_streak[i] + 1;
                    else
                        m_streak[i] = 1;
                    m_sym[i] = sym;
                    if (m_streak[i] >= th) begin
                        m_pend[i]   = 1'b1;
                        m_osym[i]   = sym;
                        m_oprice[i] = price;
                        m_streak[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("u0.ord_valid", 64'(b0.ord_valid), 64'(m_pend[0]));
        chk("u1.ord_valid", 64'(b1.ord_valid), 64'(m_pend[1]));
        chk("u0.busy", 64'(busy0), 64'(m_pend[0] || m_cool[0] > 0));
        chk("u1.busy", 64'(busy1), 64'(m_pend[1] || m_cool[1] > 0));
        chk("u0.drop_cnt", 64'(drop0), 64'(m_drop[0]));
        chk("u1.drop_cnt", 64'(drop1), 64'(m_drop[1]));
        if (m_pend[0]) begin
            chk("u0.ord_sym_id", 64'(b0.ord_sym_id), 64'(m_osym[0]));
            chk("u0.ord_price", 64'(b0.ord_price), 64'(m_oprice[0]));
        end
        if (m_pend[1]) begin
            chk("u1.ord_sym_id", 64'(b1.ord_sym_id), 64'(m_osym[1]));
            chk("u1.ord_price", 64'(b1.ord_price), 64'(m_oprice[1]));
        end
    endtask

    task automatic drive(input logic v, input logic t,
                         input logic [15:0] sym,
                         input logic [31:0] price,
                         input logic rdy);
        b0.cmp_valid = v;  b1.cmp_valid = v;
        b0.cond_true = t;  b1.cond_true = t;
        b0.cmp_sym_id = sym;  b1.cmp_sym_id = sym;
        b0.cmp_price = price;  b1.cmp_price = price;
        b0.ord_ready = rdy;  b1.ord_ready = rdy;
    endtask

    task automatic step(input logic v, input logic t,
                        input logic [15:0] sym,
                        input logic [31:0] price,
                        input logic rdy);
        drive(v, t, sym, price, rdy);
        @(posedge clk);
        model_edge(v, t, sym, price, rdy);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 16'h0, 32'h0, 1);
    endtask

    initial begin
        reset = 1'b1;
        cfg_enable = 1'b1;
        cfg_hit_thresh = 4'd3;
        drive(0, 0, 16'h0, 32'h0, 1);
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        // Threshold of three on one symbol, then the full cooldown.
        step(1, 1, 16'h0042, 32'd100, 1);
        step(1, 1, 16'h0042, 32'd101, 1);
        step(1, 1, 16'h0042, 32'd102, 1);
        chk("req39.price", 64'(b0.ord_price), 64'd102);
        idle(10);

        // A symbol change restarts the streak.
        cfg_hit_thresh = 4'd2;
        step(1, 1, 16'd5, 32'd10, 1);
        step(1, 1, 16'd7, 32'd11, 1);
        step(1, 1, 16'd7, 32'd12, 1);
        idle(10);

        // Backpressure with hits dropped while pending.
        cfg_hit_thresh = 4'd1;
        step(1, 1, 16'd9, 32'd500, 0);
        for (int k = 0; k < 4; k++)
            step(1, 1, 16'(20 + k), 32'(600 + k), 0);
        chk("req41.drop", 64'(drop0), 64'd4);
        step(0, 0, 16'h0, 32'h0, 1);
        idle(10);

        // Threshold 0 acts as 1; disabled trigger ignores hits.
        cfg_hit_thresh = 4'd0;
        step(1, 1, 16'd3, 32'd77, 1);
        idle(10);
        cfg_enable = 1'b0;
        for (int k = 0; k < 10; k++) step(1, 1, 16'd3, 32'(k), 1);
        cfg_enable = 1'b1;
        idle(2);

        // Back-to-back orders when there is no cooldown.
        cfg_hit_thresh = 4'd1;
        step(1, 1, 16'd4, 32'd40, 1);
        step(0, 0, 16'd0, 32'd0, 1);
        step(1, 1, 16'd4, 32'd41, 1);
        idle(10);

        // Asynchronous reset in the middle of an ISSUE.
        step(1, 1, 16'd8, 32'd80, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b0;
        step(1, 1, 16'd8, 32'd81, 1);
        idle(10);

        // Randomised traffic over a few symbols.
        for (int k = 0; k < 500; k++) begin
            cfg_enable = ($urandom % 10) != 0;
            cfg_hit_thresh = 4'($urandom_range(0, 4));
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 16'($urandom_range(1, 3)), $urandom,
                 ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trade_trigger.md
TRADE_TRIGGER -- requirements
Module: trade_trigger

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 16: symbol identifier width.
REQ-002 SHALL have parameter PRICE_WIDTH, default 32: price width, equal to the upstream comparator data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 4: width of the hit threshold and the hit counter.
REQ-004 SHALL have parameter COOLDOWN_CYCLES, default 8: idle cycles enforced after each accepted order; 0 means no cooldown.
REQ-005 SHALL have port clk, input, 1: core clock; the block uses one clock only, and all flops are on clk rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port cfg_enable, input, 1: arms the trigger.
REQ-008 SHALL have port cfg_hit_thresh, input, CNT_WIDTH: consecutive same-symbol hits required; 0 behaves as 1.
REQ-009 SHALL have port cmp_valid, input, 1: a comparator result is present this cycle.
REQ-010 SHALL have port cond_true, input, 1: comparator result; high means value_hi > value_lo.
REQ-011 SHALL have port cmp_sym_id, input, SYM_WIDTH: symbol of the compared tick.
REQ-012 SHALL have port cmp_price, input, PRICE_WIDTH: tick price accompanying the result.
REQ-013 SHALL have port ord_valid, output, 1: order request valid.
REQ-014 SHALL have port ord_ready, input, 1: downstream accepts the order.
REQ-015 SHALL have port ord_sym_id, output, SYM_WIDTH: order symbol.
REQ-016 SHALL have port ord_price, output, PRICE_WIDTH: order price.
REQ-017 SHALL have port busy, output, 1: high in ISSUE or COOLDOWN.
REQ-018 SHALL have port drop_cnt, output, 16: count of suppressed true results, saturating at 0xFFFF.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE and COOLDOWN.
REQ-020 IDLE, cmp_valid=1, cond_true=0: SHALL clear the hit counter.
REQ-021 IDLE, cmp_valid=1, cond_true=1, counter nonzero, cmp_sym_id equal to the tracked symbol: SHALL increment the counter.
REQ-022 IDLE, cmp_valid=1, cond_true=1, counter zero or a different symbol: SHALL set the counter to 1 and capture cmp_sym_id as the tracked symbol.
REQ-023 IDLE, cmp_valid=0: SHALL hold the counter and tracked symbol unchanged.
REQ-024 When a hit makes the new count >= max(cfg_hit_thresh,1) with cfg_enable=1, the block SHALL register cmp_sym_id/cmp_price into ord_sym_id/ord_price, clear the counter, and enter ISSUE.
REQ-025 ord_valid SHALL assert in the cycle after the triggering cmp_valid cycle (1-cycle latency).
REQ-026 cfg_enable=0 in IDLE: SHALL hold the counter at 0, never trigger, and leave drop_cnt unchanged.
REQ-027 ISSUE: ord_valid SHALL be 1, and ord_sym_id/ord_price SHALL be stable until accepted.
REQ-028 ISSUE, ord_valid=1 and ord_ready=1: SHALL leave ISSUE on the next edge, entering COOLDOWN with the cooldown counter set to COOLDOWN_CYCLES, or IDLE if COOLDOWN_CYCLES=0.
REQ-029 cfg_enable deasserting during ISSUE SHALL NOT withdraw ord_valid; the order completes normally.
REQ-030 COOLDOWN SHALL decrement the cooldown counter each cycle and enter IDLE on the edge where it equals 1, giving exactly COOLDOWN_CYCLES busy cycles after acceptance.
REQ-031 In ISSUE and COOLDOWN, comparator inputs SHALL NOT affect the hit counter or the order fields.
REQ-032 In ISSUE and COOLDOWN, each cmp_valid=1 and cond_true=1 cycle SHALL increment drop_cnt, saturating at 0xFFFF.
REQ-033 The hit counter SHALL saturate at its maximum, 2^CNT_WIDTH-1, and never wrap.
REQ-034 cfg_hit_thresh SHALL be sampled each cycle; lowering it below the current count triggers on the next qualifying hit, not spontaneously.
REQ-035 On the first IDLE cycle after COOLDOWN, a valid hit SHALL be processed normally from a counter value of 0.

Reset
REQ-036 While reset=1, the FSM SHALL be IDLE and ord_valid, busy, the hit counter, the cooldown counter, the tracked symbol, ord_sym_id, ord_price and drop_cnt SHALL all be 0, asynchronously.
REQ-037 Reset asserted mid-ISSUE SHALL drop ord_valid immediately, with no order accepted.
REQ-038 After reset release, the first edge SHALL behave as IDLE.

Verification
REQ-039 Threshold: thresh=3, COOLDOWN=8, three valid true results sym 0x0042 with prices 100/101/102, ord_ready=1 -> ord_valid for one cycle the cycle after the third result, with sym 0x0042 and price 102; busy for 9 cycles total.
REQ-040 Streak break: thresh=2, true sym 5, then true sym 7, then true sym 7 -> a single order, sym 7, after the third result.
REQ-041 Backpressure: order pending, ord_ready=0 for 4 cycles with true results each cycle -> ord_valid and its fields stable, drop_cnt=4, then acceptance on ready.
REQ-042 Thresh 0 and disable: thresh=0 with one true result -> order the next cycle; cfg_enable=0 with 10 true results -> no order and drop_cnt unchanged.
REQ-043 Async reset: assert reset during ISSUE between clock edges -> ord_valid=0 and drop_cnt=0 immediately, and IDLE after release.
REQ-044 COOLDOWN_CYCLES=0: order accepted in cycle N, true result in cycle N+1 with thresh=1 -> next ord_valid in cycle N+2.
